// File: rtl/usb_tx_pkt_sched_if.sv
// usb_tx_pkt_sched_if: requester, payload and NRZI-encoder signals of the
// USB transmit packet scheduler, with master (scheduler) / slave modports.
//   req/pid0/pid1/len0/len1 : packet requests and their descriptors
//   gnt/pkt_done/pkt_err    : grant and end-of-packet status
//   byte_in/byte_valid/byte_ack : payload byte handshake
//   start_nrzi/bit_out/nrzi_done/busy : encoder stream and status
interface usb_tx_pkt_sched_if #(
  parameter int MAX_BYTES = 64,
  parameter int LW        = $clog2(MAX_BYTES + 1)
);
  logic [1:0]    req;
  logic [7:0]    pid0;
  logic [7:0]    pid1;
  logic [LW-1:0] len0;
  logic [LW-1:0] len1;
  logic [1:0]    gnt;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ack;
  logic          pkt_done;
  logic          pkt_err;
  logic          start_nrzi;
  logic          bit_out;
  logic          nrzi_done;
  logic          busy;

  modport master (
    input  req, pid0, pid1, len0, len1,
    input  byte_in, byte_valid,
    output gnt, byte_ack, pkt_done, pkt_err,
    output start_nrzi, bit_out, nrzi_done, busy
  );

  modport slave (
    output req, pid0, pid1, len0, len1,
    output byte_in, byte_valid,
    input  gnt, byte_ack, pkt_done, pkt_err,
    input  start_nrzi, bit_out, nrzi_done, busy
  );
endinterface

// File: rtl/usb_tx_pkt_sched.sv
// usb_tx_pkt_sched: arbitrates two packet requesters and serialises the
// granted packet (SYNC, PID, payload) with bit stuffing for the NRZI encoder.
// Ports: clk, rst_n (async, active-low), bus (usb_tx_pkt_sched_if.master).
// Build option: USB_TX_RR_ARB_EN selects round-robin arbitration instead of
// fixed priority (requester 0 first).
module usb_tx_pkt_sched #(
  parameter int MAX_BYTES  = 64,
  parameter int LW         = $clog2(MAX_BYTES + 1),
  parameter int EOP_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  usb_tx_pkt_sched_if.master bus
);

  localparam int EW = $clog2(EOP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SYNC,
    S_PID,
    S_DATA,
    S_EOPW
  } state_t;

  state_t        state, state_d;
  logic [1:0]    owner, owner_d;
  logic [7:0]    sh, sh_d;
  logic [2:0]    bcnt, bcnt_d;
  logic [LW-1:0] rem, rem_d;
  logic [2:0]    ones, ones_d;
  logic          fin, fin_d;
  logic          err, err_d;
  logic          tail, tail_d;
  logic [EW-1:0] ecnt, ecnt_d;

  logic [1:0]    win;
  logic [LW-1:0] len_sel;
  logic [LW-1:0] len_clamp;

  logic          bit_o;
  logic          nd_o;
  logic          ack_o;
  logic          done_o;
  logic          perr_o;

`ifdef USB_TX_RR_ARB_EN
  // prio=1 favours requester 1 on a tie
  logic prio;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (state == S_GRANT) begin
      prio <= owner[0];
    end
  end

  always_comb begin
    win = 2'b00;
    if (bus.req == 2'b11) begin
      win = prio ? 2'b10 : 2'b01;
    end else if (bus.req[0]) begin
      win = 2'b01;
    end else if (bus.req[1]) begin
      win = 2'b10;
    end
  end
`else
  always_comb begin
    win = 2'b00;
    if (bus.req[0]) begin
      win = 2'b01;
    end else if (bus.req[1]) begin
      win = 2'b10;
    end
  end
`endif

  assign len_sel   = owner[0] ? bus.len0 : bus.len1;
  assign len_clamp = (len_sel > LW'(MAX_BYTES)) ?
                     LW'(MAX_BYTES) : len_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      owner <= 2'b00;
      sh    <= 8'h00;
      bcnt  <= 3'd0;
      rem   <= '0;
      ones  <= 3'd0;
      fin   <= 1'b0;
      err   <= 1'b0;
      tail  <= 1'b0;
      ecnt  <= '0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      sh    <= sh_d;
      bcnt  <= bcnt_d;
      rem   <= rem_d;
      ones  <= ones_d;
      fin   <= fin_d;
      err   <= err_d;
      tail  <= tail_d;
      ecnt  <= ecnt_d;
    end
  end

  always_comb begin
    state_d = state;
    owner_d = owner;
    sh_d    = sh;
    bcnt_d  = bcnt;
    rem_d   = rem;
    ones_d  = ones;
    fin_d   = fin;
    err_d   = err;
    tail_d  = tail;
    ecnt_d  = ecnt;
    bit_o   = 1'b0;
    nd_o    = 1'b0;
    ack_o   = 1'b0;
    done_o  = 1'b0;
    perr_o  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (|bus.req) begin
          state_d = S_GRANT;
          owner_d = win;
        end
      end
      S_GRANT: begin
        sh_d    = owner[0] ? bus.pid0 : bus.pid1;
        rem_d   = len_clamp;
        bcnt_d  = 3'd0;
        ones_d  = 3'd0;
        fin_d   = 1'b0;
        err_d   = 1'b0;
        tail_d  = 1'b0;
        state_d = S_SYNC;
      end
      S_SYNC: begin
        bit_o  = (bcnt == 3'd7);
        bcnt_d = bcnt + 3'd1;
        if (bcnt == 3'd7) begin
          ones_d  = 3'd1;
          state_d = S_PID;
        end
      end
      S_PID, S_DATA: begin
        if (fin) begin
          // status cycle after the final bit; grant still held
          done_o  = !err;
          perr_o  = err;
          fin_d   = 1'b0;
          ecnt_d  = '0;
          state_d = S_EOPW;
        end else if (ones == 3'd6) begin
          // stuff bit: shifter and fetch stay frozen
          ones_d = 3'd0;
          if (tail) begin
            nd_o   = 1'b1;
            fin_d  = 1'b1;
            tail_d = 1'b0;
          end
        end else begin
          bit_o  = sh[0];
          ones_d = sh[0] ? ones + 3'd1 : 3'd0;
          sh_d   = {1'b0, sh[7:1]};
          bcnt_d = bcnt + 3'd1;
          if (bcnt == 3'd7) begin
            if (rem == '0) begin
              // last bit; a completed run of six defers done to the stuff
              if (sh[0] && ones == 3'd5) begin
                tail_d = 1'b1;
              end else begin
                nd_o  = 1'b1;
                fin_d = 1'b1;
              end
            end else if (bus.byte_valid) begin
              ack_o   = 1'b1;
              sh_d    = bus.byte_in;
              rem_d   = rem - LW'(1);
              state_d = S_DATA;
            end else begin
              // underrun: this bit ends the packet
              nd_o  = 1'b1;
              fin_d = 1'b1;
              err_d = 1'b1;
            end
          end
        end
      end
      S_EOPW: begin
        if (ecnt == EW'(EOP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          ecnt_d = ecnt + EW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.gnt = (state == S_GRANT || state == S_SYNC ||
                    state == S_PID || state == S_DATA) ?
                   owner : 2'b00;
  assign bus.start_nrzi = (state == S_GRANT);
  assign bus.busy       = (state != S_IDLE);
  assign bus.bit_out    = bit_o;
  assign bus.nrzi_done  = nd_o;
  assign bus.byte_ack   = ack_o;
  assign bus.pkt_done   = done_o;
  assign bus.pkt_err    = perr_o;

endmodule

// File: tb/tb_usb_tx_pkt_sched.sv
// tb_usb_tx_pkt_sched: directed bench for usb_tx_pkt_sched.
// Records each packet cycle by cycle and checks against hand-built streams.
module tb_usb_tx_pkt_sched;

  localparam int LW = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  usb_tx_pkt_sched_if #(.MAX_BYTES(64)) bus ();

  usb_tx_pkt_sched #(
    .MAX_BYTES(64),
    .EOP_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic       r_bit  [0:599];
  logic       r_nd   [0:599];
  logic       r_ack  [0:599];
  logic       r_pd   [0:599];
  logic       r_pe   [0:599];
  logic       r_st   [0:599];
  logic       r_busy [0:599];
  logic [1:0] r_gnt  [0:599];

  logic [7:0] plan_byte [0:127];
  int plan_valid = 0;
  int bi = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      #1;
      if (bus.start_nrzi === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      bus.byte_valid = (bi < plan_valid);
      bus.byte_in = (bi < 128) ? plan_byte[bi] : 8'h00;
      #1;
      r_bit[i]  = bus.bit_out;
      r_nd[i]   = bus.nrzi_done;
      r_ack[i]  = bus.byte_ack;
      r_pd[i]   = bus.pkt_done;
      r_pe[i]   = bus.pkt_err;
      r_st[i]   = bus.start_nrzi;
      r_busy[i] = bus.busy;
      r_gnt[i]  = bus.gnt;
      if (bus.byte_ack === 1'b1) bi++;
      tick();
    end
  endtask

  function automatic logic [63:0] pack(input int first, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = r_bit[first + i];
    return v;
  endfunction

  function automatic logic pick(input int kind, input int i);
    case (kind)
      0: return r_nd[i];
      1: return r_pd[i];
      2: return r_pe[i];
      3: return r_ack[i];
      default: return r_st[i];
    endcase
  endfunction

  function automatic int first_of(input int kind, input int n);
    for (int i = 0; i < n; i++) if (pick(kind, i) === 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_of(input int kind, input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (pick(kind, i) === 1'b1) c++;
    return c;
  endfunction

  function automatic logic [8:0] outs();
    return {bus.gnt, bus.byte_ack, bus.pkt_done, bus.pkt_err,
            bus.start_nrzi, bus.bit_out, bus.nrzi_done, bus.busy};
  endfunction

  task automatic start_pkt(input logic [1:0] r, input string nm);
    bit ok;
    bi = 0;
    bus.req = r;
    wait_grant(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s_grant_timeout: got none want start_nrzi", nm);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (outs() !== 9'h000) begin
      n_bad++;
      $display("FAIL reset_outs: got %h want 000", outs());
    end
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (outs() !== 9'h000) begin
      n_bad++;
      $display("FAIL idle_outs: got %h want 000", outs());
    end
  endtask

  task automatic test_token();
    bus.pid0 = 8'h69;
    bus.len0 = '0;
    plan_valid = 0;
    start_pkt(2'b01, "tok");
    bus.req = 2'b00;
    record(24);
    n_cmp++;
    if (r_gnt[0] !== 2'b01) begin
      n_bad++;
      $display("FAIL tok_gnt: got %b want 01", r_gnt[0]);
    end
    n_cmp++;
    if (count_of(4, 24) !== 1) begin
      n_bad++;
      $display("FAIL tok_start: got %0d want 1", count_of(4, 24));
    end
    n_cmp++;
    if (pack(1, 16) !== 64'h6980) begin
      n_bad++;
      $display("FAIL tok_bits: got %h want 6980", pack(1, 16));
    end
    n_cmp++;
    if (first_of(0, 24) !== 16 || count_of(0, 24) !== 1) begin
      n_bad++;
      $display("FAIL tok_nd: got %0d want 16", first_of(0, 24));
    end
    n_cmp++;
    if (first_of(1, 24) !== 17 || r_gnt[17] !== 2'b01) begin
      n_bad++;
      $display("FAIL tok_done: got %0d want 17", first_of(1, 24));
    end
    n_cmp++;
    if (r_gnt[18] !== 2'b00) begin
      n_bad++;
      $display("FAIL tok_gnt_eop: got %b want 00", r_gnt[18]);
    end
    n_cmp++;
    if (r_busy[20] !== 1'b1 || r_busy[21] !== 1'b0) begin
      n_bad++;
      $display("FAIL tok_busy: got %b%b want 10", r_busy[20], r_busy[21]);
    end
  endtask

  task automatic test_stuffing();
    bus.pid1 = 8'hC3;
    bus.len1 = LW'(1);
    plan_byte[0] = 8'hFF;
    plan_valid = 1;
    start_pkt(2'b10, "stf");
    bus.req = 2'b00;
    record(31);
    n_cmp++;
    if (r_gnt[0] !== 2'b10) begin
      n_bad++;
      $display("FAIL stf_gnt: got %b want 10", r_gnt[0]);
    end
    n_cmp++;
    if (pack(1, 25) !== 64'h1EFC380) begin
      n_bad++;
      $display("FAIL stf_bits: got %h want 1efc380", pack(1, 25));
    end
    n_cmp++;
    if (count_of(3, 31) !== 1 || r_ack[16] !== 1'b1) begin
      n_bad++;
      $display("FAIL stf_ack: got %0d want 1", count_of(3, 31));
    end
    n_cmp++;
    if (first_of(0, 31) !== 25) begin
      n_bad++;
      $display("FAIL stf_nd: got %0d want 25", first_of(0, 31));
    end
    n_cmp++;
    if (first_of(1, 31) !== 26 || r_gnt[26] !== 2'b10) begin
      n_bad++;
      $display("FAIL stf_done: got %0d want 26", first_of(1, 31));
    end
  endtask

  task automatic test_simultaneous();
    bus.pid0 = 8'h69;
    bus.len0 = '0;
    bus.pid1 = 8'hE1;
    bus.len1 = '0;
    plan_valid = 0;
    start_pkt(2'b11, "sim1");
    n_cmp++;
    if (bus.gnt !== 2'b01) begin
      n_bad++;
      $display("FAIL sim_gnt1: got %b want 01", bus.gnt);
    end
`ifdef USB_TX_RR_ARB_EN
    bus.req = 2'b11;
`else
    bus.req = 2'b10;
`endif
    record(21);
    start_pkt(bus.req, "sim2");
    n_cmp++;
    if (bus.gnt !== 2'b10) begin
      n_bad++;
      $display("FAIL sim_gnt2: got %b want 10", bus.gnt);
    end
    bus.req = 2'b11;
    record(21);
    n_cmp++;
    if (pack(9, 8) !== 64'hE1) begin
      n_bad++;
      $display("FAIL sim_pid2: got %h want e1", pack(9, 8));
    end
    start_pkt(2'b11, "sim3");
    n_cmp++;
    if (bus.gnt !== 2'b01) begin
      n_bad++;
      $display("FAIL sim_gnt3: got %b want 01", bus.gnt);
    end
    bus.req = 2'b00;
    record(22);
  endtask

  task automatic test_underrun();
    bus.pid0 = 8'h69;
    bus.len0 = LW'(3);
    plan_byte[0] = 8'h5A;
    plan_valid = 1;
    start_pkt(2'b01, "unr");
    bus.req = 2'b00;
    record(32);
    n_cmp++;
    if (pack(1, 24) !== 64'h5A6980) begin
      n_bad++;
      $display("FAIL unr_bits: got %h want 5a6980", pack(1, 24));
    end
    n_cmp++;
    if (count_of(3, 32) !== 1) begin
      n_bad++;
      $display("FAIL unr_ack: got %0d want 1", count_of(3, 32));
    end
    n_cmp++;
    if (first_of(0, 32) !== 24 || count_of(0, 32) !== 1) begin
      n_bad++;
      $display("FAIL unr_nd: got %0d want 24", first_of(0, 32));
    end
    n_cmp++;
    if (first_of(2, 32) !== 25 || r_gnt[25] !== 2'b01) begin
      n_bad++;
      $display("FAIL unr_err: got %0d want 25", first_of(2, 32));
    end
    n_cmp++;
    if (count_of(1, 32) !== 0) begin
      n_bad++;
      $display("FAIL unr_nodone: got %0d want 0", count_of(1, 32));
    end
    n_cmp++;
    if (r_busy[28] !== 1'b1 || r_busy[29] !== 1'b0) begin
      n_bad++;
      $display("FAIL unr_busy: got %b%b want 10", r_busy[28], r_busy[29]);
    end
  endtask

  task automatic test_tail_stuff();
    bus.pid0 = 8'hC3;
    bus.len0 = LW'(1);
    plan_byte[0] = 8'hFC;
    plan_valid = 1;
    start_pkt(2'b01, "tail");
    bus.req = 2'b00;
    record(31);
    n_cmp++;
    if (pack(1, 25) !== 64'h0FCC380) begin
      n_bad++;
      $display("FAIL tail_bits: got %h want 0fcc380", pack(1, 25));
    end
    n_cmp++;
    if (r_nd[24] !== 1'b0 || first_of(0, 31) !== 25) begin
      n_bad++;
      $display("FAIL tail_nd: got %0d want 25", first_of(0, 31));
    end
    n_cmp++;
    if (first_of(1, 31) !== 26) begin
      n_bad++;
      $display("FAIL tail_done: got %0d want 26", first_of(1, 31));
    end
  endtask

  task automatic test_clamp();
    bus.pid0 = 8'h69;
    bus.len0 = LW'(127);
    for (int i = 0; i < 70; i++) plan_byte[i] = 8'h00;
    plan_valid = 70;
    start_pkt(2'b01, "clp");
    bus.req = 2'b00;
    record(540);
    n_cmp++;
    if (count_of(3, 540) !== 64) begin
      n_bad++;
      $display("FAIL clp_acks: got %0d want 64", count_of(3, 540));
    end
    n_cmp++;
    if (first_of(0, 540) !== 528) begin
      n_bad++;
      $display("FAIL clp_nd: got %0d want 528", first_of(0, 540));
    end
    n_cmp++;
    if (first_of(1, 540) !== 529) begin
      n_bad++;
      $display("FAIL clp_done: got %0d want 529", first_of(1, 540));
    end
  endtask

  task automatic test_reset_mid();
    bus.pid0 = 8'h69;
    bus.len0 = LW'(3);
    for (int i = 0; i < 3; i++) plan_byte[i] = 8'h33;
    plan_valid = 3;
    start_pkt(2'b01, "rmid");
    bus.req = 2'b00;
    record(20);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== 9'h000) begin
      n_bad++;
      $display("FAIL rmid_outs: got %h want 000", outs());
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    bus.pid0 = 8'h2D;
    bus.len0 = '0;
    plan_valid = 0;
    start_pkt(2'b01, "rmid2");
    n_cmp++;
    if (bus.gnt !== 2'b01) begin
      n_bad++;
      $display("FAIL rmid_gnt: got %b want 01", bus.gnt);
    end
    bus.req = 2'b00;
    record(24);
    n_cmp++;
    if (pack(1, 16) !== 64'h2D80) begin
      n_bad++;
      $display("FAIL rmid_bits: got %h want 2d80", pack(1, 16));
    end
    n_cmp++;
    if (first_of(1, 24) !== 17) begin
      n_bad++;
      $display("FAIL rmid_done: got %0d want 17", first_of(1, 24));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.req = 2'b00;
    bus.pid0 = 8'h00;
    bus.pid1 = 8'h00;
    bus.len0 = '0;
    bus.len1 = '0;
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;
    test_reset();
    test_token();
    test_stuffing();
    test_simultaneous();
    test_underrun();
    test_tail_stuff();
    test_clamp();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
